multicycle_ctrl_v2: RTL and testbench
=====================================

Name: multicycle_ctrl_v2

Overview:
Parametrised multicycle control unit for the MIPS-subset datapath. Sequences fetch, decode, execute and writeback, and drives every datapath mux and write-enable as a Moore decode of a state register. Successor to the fixed-timing controller, adding:
- configurable memory wait states;
- BEQ/BNE/J support;
- overflow and illegal-opcode exceptions (EPC plus vector).

Parameters:
MEM_WAIT, 1, extra cycles between memory address valid and read data valid (0..15)
EXC_ENABLE, 1, 1 = trap on illegal opcode and overflow; 0 = illegal opcode is a NOP and overflow is ignored
VEC_SEL, 2'b11, pc_source value that selects the exception vector

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = asserted)
op_code  in  6  IR[31:26]
funct  in  6  IR[5:0]
overflow  in  1  ALU overflow flag, combinational, valid during EXEC
i_or_d  out  2  memory address select (0 = PC)
pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, VEC_SEL = vector
pc_write  out  1  unconditional PC write
pc_control  out  1  conditional PC write; datapath qualifies it with the compare result
branch_ne  out  1  0 = take on zero (BEQ), 1 = take on non-zero (BNE)
ir_write  out  1  IR load
memory_write  out  1  memory write strobe
reg_write  out  1  register file write
a_b_write  out  1  A/B register load
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-extended immediate, 3 = branch offset
alu_op  out  3  LOAD=000, ADD=001, SUB=010, AND=011
alu_out_write  out  1  ALUOut load
mem_to_reg  out  3  register-file write data select (7 = stack-pointer constant)
reg_dist_ctrl  out  2  0 = rt, 2 = $29, 3 = rd
epc_write  out  1  EPC load
exc_code  out  2  0 = none, 1 = illegal opcode, 2 = overflow; held until the next FETCH
state_out  out  5  current state encoding, for debug

Behaviour:
- All outputs are a combinational decode of the state register; any output not listed for a state is 0.
- Only the state register, wait_cnt and exc_code are sequential.
- States: RST_SP, FETCH, MWAIT, IR_LOAD, DECODE, EXEC_R, EXEC_I, BRANCH, JUMP, WB_R, WB_I, EXC_EPC, EXC_VEC.
- Reset asserted (any time, mid-instruction included):
  - state goes to RST_SP immediately; wait_cnt = 0, exc_code = 0.
  - RST_SP drives reg_write=1, mem_to_reg=7, reg_dist_ctrl=2. memory_write is guaranteed 0.
- RST_SP → FETCH on the first clock edge after reset deasserts.
- FETCH: i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. Next state is MWAIT if MEM_WAIT>0, else IR_LOAD.
- MWAIT: same outputs as FETCH. wait_cnt increments each cycle; on wait_cnt == MEM_WAIT-1 it clears and the state moves to IR_LOAD. Total fetch = 2+MEM_WAIT cycles.
- IR_LOAD: FETCH outputs plus ir_write=1, pc_write=1, pc_source=0. Next state DECODE.
- DECODE: a_b_write=1, alu_src_a=0, alu_src_b=3, alu_op=ADD, alu_out_write=1 (branch target precomputed). Dispatch:
  - R-type with funct ADD(100000), SUB(100010) or AND(100100) → EXEC_R
  - ADDI(001000), ADDIU(001001) → EXEC_I
  - BEQ(000100), BNE(000101) → BRANCH
  - J(000010) → JUMP
  - anything else → EXC_EPC with exc_code=1 if EXC_ENABLE, otherwise → FETCH
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op per funct, alu_out_write=1. Next state WB_R, unless overflow=1 on ADD/SUB with EXC_ENABLE set, which goes to EXC_EPC with exc_code=2.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=ADD, alu_out_write=1. Overflow traps only for ADDI; ADDIU never traps. Non-trapping next state WB_I.
- WB_R: reg_write=1, reg_dist_ctrl=3, mem_to_reg=0. WB_I: reg_write=1, reg_dist_ctrl=0, mem_to_reg=0. Both → FETCH.
- A trapped instruction never asserts reg_write.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_control=1, pc_source=1, branch_ne = op_code[0]. → FETCH.
- JUMP: pc_write=1, pc_source=2. → FETCH.
- EXC_EPC: alu_src_a=0, alu_src_b=1, alu_op=SUB (PC-4), epc_write=1. → EXC_VEC.
- EXC_VEC: pc_write=1, pc_source=VEC_SEL. → FETCH.
- exc_code clears on entry to FETCH.
- Unreachable state encodings → FETCH.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum;
  - opcode and funct constants;
  - ALU op codes;
  - mux-select constants (ALUSRCB_*, PCSRC_*, REGDST_*, MTR_SP);
  - exc_code values.
- One sub-module, ctrl_decode: purely combinational op_code/funct → dispatch-class and alu_op lookup, shared with future controllers.

Test Plan:
- Reset held low for 3 cycles then released, MEM_WAIT=2 → RST_SP with reg_write=1/mem_to_reg=7/reg_dist_ctrl=2 throughout; FETCH on the first edge after release; ir_write high exactly 3 cycles after FETCH entry.
- ADD (op 000000, funct 100000), overflow=0, MEM_WAIT=0 → state sequence FETCH, IR_LOAD, DECODE, EXEC_R, WB_R; alu_op=001 in EXEC_R; reg_write=1 with reg_dist_ctrl=3 in WB_R.
- ADDI with overflow=1 in EXEC_I → EXC_EPC (epc_write=1, alu_op=010), then EXC_VEC (pc_source=11, pc_write=1); exc_code=2; reg_write never asserted. Same stimulus with ADDIU → WB_I and no trap.
- op_code 111111 → exc_code=1 and the trap path; with EXC_ENABLE=0 → DECODE goes directly to FETCH with no write enables asserted.
- BNE (000101) → BRANCH with pc_control=1, branch_ne=1, pc_source=01, pc_write=0. J → JUMP with pc_write=1, pc_source=10.
- Reset asserted asynchronously mid-MWAIT (between clock edges) → state_out = RST_SP before the next edge; wait_cnt = 0; after release, a full 2+MEM_WAIT-cycle fetch is observed.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controllers: states, opcodes,
// ALU operations, datapath mux selects and exception codes.
package ctrl_pkg;

  typedef enum logic [4:0] {
    StRstSp  = 5'd0,
    StFetch  = 5'd1,
    StMwait  = 5'd2,
    StIrLoad = 5'd3,
    StDecode = 5'd4,
    StExecR  = 5'd5,
    StExecI  = 5'd6,
    StBranch = 5'd7,
    StJump   = 5'd8,
    StWbR    = 5'd9,
    StWbI    = 5'd10,
    StExcEpc = 5'd11,
    StExcVec = 5'd12
  } state_e;

  typedef enum logic [2:0] {
    DispR,
    DispI,
    DispBranch,
    DispJump,
    DispIllegal
  } disp_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;

  localparam logic [2:0] ALU_LOAD = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [1:0] ALUSRCB_B    = 2'd0;
  localparam logic [1:0] ALUSRCB_FOUR = 2'd1;
  localparam logic [1:0] ALUSRCB_IMM  = 2'd2;
  localparam logic [1:0] ALUSRCB_BR   = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_SP = 2'd2;
  localparam logic [1:0] REGDST_RD = 2'd3;

  localparam logic [2:0] MTR_ALUOUT = 3'd0;
  localparam logic [2:0] MTR_SP     = 3'd7;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ILLEGAL = 2'd1;
  localparam logic [1:0] EXC_OVF     = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: dispatch class, ALU operation and
// whether the instruction traps on arithmetic overflow.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output disp_e      disp_class,
  output logic [2:0] alu_op,
  output logic       ovf_trap
);

  always_comb begin
    disp_class = DispIllegal;
    alu_op     = ALU_LOAD;
    ovf_trap   = 1'b0;
    case (op_code)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            disp_class = DispR;
            alu_op     = ALU_ADD;
            ovf_trap   = 1'b1;
          end
          FN_SUB: begin
            disp_class = DispR;
            alu_op     = ALU_SUB;
            ovf_trap   = 1'b1;
          end
          FN_AND: begin
            disp_class = DispR;
            alu_op     = ALU_AND;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        disp_class = DispI;
        alu_op     = ALU_ADD;
        ovf_trap   = 1'b1;
      end
      OP_ADDIU: begin
        disp_class = DispI;
        alu_op     = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        disp_class = DispBranch;
        alu_op     = ALU_SUB;
      end
      OP_J: disp_class = DispJump;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle control unit: Moore decode of the state register drives every datapath
// select and write enable; memory wait states and exceptions are parametrised.
module multicycle_ctrl_v2
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 1,
  parameter bit          EXC_ENABLE = 1'b1,
  parameter logic [1:0]  VEC_SEL    = 2'b11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  input  logic       overflow,
  output logic [1:0] i_or_d,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_control,
  output logic       branch_ne,
  output logic       ir_write,
  output logic       memory_write,
  output logic       reg_write,
  output logic       a_b_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       alu_out_write,
  output logic [2:0] mem_to_reg,
  output logic [1:0] reg_dist_ctrl,
  output logic       epc_write,
  output logic [1:0] exc_code,
  output logic [4:0] state_out
);

  localparam logic [3:0] WaitLast = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] exc_code_q, exc_code_d;

  disp_e      dec_class;
  logic [2:0] dec_alu_op;
  logic       dec_ovf_trap;

  ctrl_decode u_decode (
    .op_code   (op_code),
    .funct     (funct),
    .disp_class(dec_class),
    .alu_op    (dec_alu_op),
    .ovf_trap  (dec_ovf_trap)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StRstSp;
      wait_cnt_q <= 4'd0;
      exc_code_q <= EXC_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      exc_code_q <= exc_code_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    exc_code_d    = exc_code_q;
    i_or_d        = 2'd0;
    pc_source     = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_control    = 1'b0;
    branch_ne     = 1'b0;
    ir_write      = 1'b0;
    memory_write  = 1'b0;
    reg_write     = 1'b0;
    a_b_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUSRCB_B;
    alu_op        = ALU_LOAD;
    alu_out_write = 1'b0;
    mem_to_reg    = MTR_ALUOUT;
    reg_dist_ctrl = REGDST_RT;
    epc_write     = 1'b0;

    case (state_q)
      StRstSp: begin
        reg_write     = 1'b1;
        mem_to_reg    = MTR_SP;
        reg_dist_ctrl = REGDST_SP;
        state_d       = StFetch;
      end
      StFetch, StMwait, StIrLoad: begin
        // PC + 4 is computed while the instruction word is on its way.
        alu_src_b = ALUSRCB_FOUR;
        alu_op    = ALU_ADD;
        if (state_q == StFetch) begin
          state_d = (MEM_WAIT > 0) ? StMwait : StIrLoad;
        end else if (state_q == StMwait) begin
          if (wait_cnt_q == WaitLast) begin
            wait_cnt_d = 4'd0;
            state_d    = StIrLoad;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end else begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        a_b_write     = 1'b1;
        alu_src_b     = ALUSRCB_BR;
        alu_op        = ALU_ADD;
        alu_out_write = 1'b1;
        case (dec_class)
          DispR:      state_d = StExecR;
          DispI:      state_d = StExecI;
          DispBranch: state_d = StBranch;
          DispJump:   state_d = StJump;
          default: begin
            if (EXC_ENABLE) begin
              state_d    = StExcEpc;
              exc_code_d = EXC_ILLEGAL;
            end else begin
              state_d = StFetch;
            end
          end
        endcase
      end
      StExecR, StExecI: begin
        alu_src_a     = 1'b1;
        alu_out_write = 1'b1;
        if (state_q == StExecR) begin
          alu_src_b = ALUSRCB_B;
          alu_op    = dec_alu_op;
          state_d   = StWbR;
        end else begin
          alu_src_b = ALUSRCB_IMM;
          alu_op    = ALU_ADD;
          state_d   = StWbI;
        end
        if (EXC_ENABLE && overflow && dec_ovf_trap) begin
          state_d    = StExcEpc;
          exc_code_d = EXC_OVF;
        end
      end
      StWbR: begin
        reg_write     = 1'b1;
        reg_dist_ctrl = REGDST_RD;
        state_d       = StFetch;
      end
      StWbI: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_control = 1'b1;
        pc_source  = PCSRC_ALUOUT;
        branch_ne  = op_code[0];
        state_d    = StFetch;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = StFetch;
      end
      StExcEpc: begin
        // EPC captures PC - 4, the address of the faulting instruction.
        alu_src_b = ALUSRCB_FOUR;
        alu_op    = ALU_SUB;
        epc_write = 1'b1;
        state_d   = StExcVec;
      end
      StExcVec: begin
        pc_write  = 1'b1;
        pc_source = VEC_SEL;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase

    if (state_d == StFetch) exc_code_d = EXC_NONE;
  end

  assign exc_code  = exc_code_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: three configurations run directed programs while a
// sequence-level model predicts every output on every cycle.
module tb_multicycle_ctrl_v2;
  import ctrl_pkg::*;

  localparam int unsigned MWV [3] = '{2, 0, 1};
  localparam bit          ENV [3] = '{1'b1, 1'b1, 1'b0};

  typedef struct packed {
    logic [1:0] i_or_d, pc_source;
    logic       pc_write, pc_control, branch_ne, ir_write, memory_write, reg_write;
    logic       a_b_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       alu_out_write;
    logic [2:0] mem_to_reg;
    logic [1:0] reg_dist_ctrl;
    logic       epc_write;
    logic [1:0] exc_code;
    logic [4:0] state;
  } obs_t;

  typedef struct packed { state_e st; logic [1:0] exc; } step_t;
  typedef struct packed { logic [5:0] op, fn; logic ov; } ins_t;

  logic clock, rst_n;
  logic [5:0] op_code [3];
  logic [5:0] funct [3];
  logic       overflow [3];
  logic [1:0] i_or_d [3], pc_source [3], alu_src_b [3], reg_dist_ctrl [3], exc_code [3];
  logic       pc_write [3], pc_control [3], branch_ne [3], ir_write [3], memory_write [3];
  logic       reg_write [3], a_b_write [3], alu_src_a [3], alu_out_write [3], epc_write [3];
  logic [2:0] alu_op [3], mem_to_reg [3];
  logic [4:0] state_out [3];

  int errors = 0;
  int checks = 0;

  step_t seq [4][16];
  int    len [4];
  int    pos [3], idx [3];
  bit    pend [3];
  ins_t  prog [3][8];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_ctrl_v2 #(
      .MEM_WAIT  (MWV[g]),
      .EXC_ENABLE(ENV[g]),
      .VEC_SEL   (2'b11)
    ) u_dut (
      .clock        (clock),
      .reset        (rst_n),
      .op_code      (op_code[g]),
      .funct        (funct[g]),
      .overflow     (overflow[g]),
      .i_or_d       (i_or_d[g]),
      .pc_source    (pc_source[g]),
      .pc_write     (pc_write[g]),
      .pc_control   (pc_control[g]),
      .branch_ne    (branch_ne[g]),
      .ir_write     (ir_write[g]),
      .memory_write (memory_write[g]),
      .reg_write    (reg_write[g]),
      .a_b_write    (a_b_write[g]),
      .alu_src_a    (alu_src_a[g]),
      .alu_src_b    (alu_src_b[g]),
      .alu_op       (alu_op[g]),
      .alu_out_write(alu_out_write[g]),
      .mem_to_reg   (mem_to_reg[g]),
      .reg_dist_ctrl(reg_dist_ctrl[g]),
      .epc_write    (epc_write[g]),
      .exc_code     (exc_code[g]),
      .state_out    (state_out[g])
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic [5:0] op, input logic [5:0] fn, input logic ov);
    return {op, fn, ov};
  endfunction

  // Instruction-level sequence: fetch phase, decode, then the class-specific tail.
  task automatic build(input int k, input logic [5:0] op, input logic [5:0] fn,
                       input logic ov, input int unsigned mw, input bit en);
    int n = 0;
    bit trap = 0;
    logic [1:0] code = 2'd0;
    seq[k][n++] = '{StFetch, 2'd0};
    for (int i = 0; i < int'(mw); i++) seq[k][n++] = '{StMwait, 2'd0};
    seq[k][n++] = '{StIrLoad, 2'd0};
    seq[k][n++] = '{StDecode, 2'd0};
    if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100)) begin
      seq[k][n++] = '{StExecR, 2'd0};
      trap = en && ov && fn != 6'b100100;
      code = 2'd2;
      if (!trap) seq[k][n++] = '{StWbR, 2'd0};
    end else if (op == 6'b001000 || op == 6'b001001) begin
      seq[k][n++] = '{StExecI, 2'd0};
      trap = en && ov && op == 6'b001000;
      code = 2'd2;
      if (!trap) seq[k][n++] = '{StWbI, 2'd0};
    end else if (op == 6'b000100 || op == 6'b000101) begin
      seq[k][n++] = '{StBranch, 2'd0};
    end else if (op == 6'b000010) begin
      seq[k][n++] = '{StJump, 2'd0};
    end else begin
      trap = en;
      code = 2'd1;
    end
    if (trap) begin
      seq[k][n++] = '{StExcEpc, code};
      seq[k][n++] = '{StExcVec, code};
    end
    len[k] = n;
  endtask

  function automatic obs_t exp_out(input state_e st, input logic [5:0] op,
                                   input logic [5:0] fn, input logic [1:0] exc);
    obs_t o = '0;
    o.state    = st;
    o.exc_code = exc;
    case (st)
      StRstSp: begin o.reg_write = 1; o.mem_to_reg = 3'd7; o.reg_dist_ctrl = 2'd2; end
      StFetch, StMwait: begin o.alu_src_b = 2'd1; o.alu_op = 3'b001; end
      StIrLoad: begin
        o.alu_src_b = 2'd1; o.alu_op = 3'b001; o.ir_write = 1; o.pc_write = 1;
      end
      StDecode: begin
        o.a_b_write = 1; o.alu_src_b = 2'd3; o.alu_op = 3'b001; o.alu_out_write = 1;
      end
      StExecR: begin
        o.alu_src_a = 1; o.alu_out_write = 1;
        o.alu_op = (fn == 6'b100010) ? 3'b010 : (fn == 6'b100100) ? 3'b011 : 3'b001;
      end
      StExecI: begin
        o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 3'b001; o.alu_out_write = 1;
      end
      StWbR: begin o.reg_write = 1; o.reg_dist_ctrl = 2'd3; end
      StWbI: o.reg_write = 1;
      StBranch: begin
        o.alu_src_a = 1; o.alu_op = 3'b010; o.pc_control = 1; o.pc_source = 2'd1;
        o.branch_ne = op[0];
      end
      StJump: begin o.pc_write = 1; o.pc_source = 2'd2; end
      StExcEpc: begin o.alu_src_b = 2'd1; o.alu_op = 3'b010; o.epc_write = 1; end
      StExcVec: begin o.pc_write = 1; o.pc_source = 2'b11; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t get_obs(input int k);
    obs_t o;
    o.i_or_d = i_or_d[k]; o.pc_source = pc_source[k]; o.pc_write = pc_write[k];
    o.pc_control = pc_control[k]; o.branch_ne = branch_ne[k]; o.ir_write = ir_write[k];
    o.memory_write = memory_write[k]; o.reg_write = reg_write[k];
    o.a_b_write = a_b_write[k]; o.alu_src_a = alu_src_a[k]; o.alu_src_b = alu_src_b[k];
    o.alu_op = alu_op[k]; o.alu_out_write = alu_out_write[k]; o.mem_to_reg = mem_to_reg[k];
    o.reg_dist_ctrl = reg_dist_ctrl[k]; o.epc_write = epc_write[k];
    o.exc_code = exc_code[k]; o.state = state_out[k];
    return o;
  endfunction

  // Compare process: advances each model on the falling edge and checks all outputs.
  initial begin
    int cyc = 0;
    obs_t e;
    ins_t ins;
    prog[0] = '{mk(6'o00, 6'b100000, 0), mk(6'o00, 6'b100010, 1), mk(6'o00, 6'b100100, 1),
                mk(6'b000100, 6'd0, 0), mk(6'b111111, 6'd0, 0), mk(6'b000010, 6'd0, 0),
                mk(6'b001000, 6'd0, 0), mk(6'b000101, 6'd0, 1)};
    prog[1] = '{mk(6'o00, 6'b100000, 0), mk(6'b001000, 6'd0, 1), mk(6'b001001, 6'd0, 1),
                mk(6'b000101, 6'd0, 0), mk(6'b000010, 6'd0, 0), mk(6'o00, 6'b100010, 0),
                mk(6'o00, 6'b000000, 0), mk(6'b111111, 6'd0, 0)};
    prog[2] = '{mk(6'b111111, 6'd0, 0), mk(6'o00, 6'b100000, 1), mk(6'b001000, 6'd0, 1),
                mk(6'b000101, 6'd0, 0), mk(6'b000100, 6'd0, 0), mk(6'o00, 6'b100100, 0),
                mk(6'b000010, 6'd0, 0), mk(6'o00, 6'b100010, 1)};
    for (int k = 0; k < 3; k++) begin
      op_code[k] = 6'd0; funct[k] = 6'd0; overflow[k] = 1'b0;
      pend[k] = 1; pos[k] = 0; len[k] = 0; idx[k] = 0;
    end
    forever begin
      @(negedge clock);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          pend[k] = 1; pos[k] = 0; len[k] = 0;
          e = exp_out(StRstSp, 6'd0, 6'd0, 2'd0);
        end else if (pend[k]) begin
          pend[k] = 0;
          e = exp_out(StRstSp, 6'd0, 6'd0, 2'd0);
        end else begin
          if (pos[k] >= len[k]) begin
            ins = prog[k][idx[k] % 8];
            idx[k]++;
            op_code[k] = ins.op; funct[k] = ins.fn; overflow[k] = ins.ov;
            build(k, ins.op, ins.fn, ins.ov, MWV[k], ENV[k]);
            pos[k] = 0;
          end
          e = exp_out(seq[k][pos[k]].st, op_code[k], funct[k], seq[k][pos[k]].exc);
          pos[k]++;
        end
        chk($sformatf("dut%0d_cycle%0d", k, cyc), 64'(get_obs(k)), 64'(e));
      end
    end
  end

  initial begin
    obs_t o;
    bit found = 0;
    rst_n = 1'b0;

    // Pin the model against hand-derived values.
    build(3, 6'b000000, 6'b100000, 0, 0, 1);
    chk("pin_add_len", len[3], 5);
    chk("pin_add_seq", {seq[3][0].st, seq[3][1].st, seq[3][2].st, seq[3][3].st, seq[3][4].st},
        {StFetch, StIrLoad, StDecode, StExecR, StWbR});
    build(3, 6'b001000, 6'd0, 1, 0, 1);
    chk("pin_addi_trap", {seq[3][4], seq[3][5]}, {StExcEpc, 2'd2, StExcVec, 2'd2});
    o = exp_out(StExecR, 6'd0, 6'b100000, 2'd0);
    chk("pin_execr_aluop", o.alu_op, 3'b001);
    o = exp_out(StBranch, 6'b000101, 6'd0, 2'd0);
    chk("pin_bne", {o.pc_control, o.branch_ne, o.pc_source, o.pc_write}, 5'b11010);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_sp_outputs", {state_out[0], reg_write[0], mem_to_reg[0], reg_dist_ctrl[0],
                           memory_write[0]}, {StRstSp, 1'b1, 3'd7, 2'd2, 1'b0});
    rst_n = 1'b1;
    @(posedge clock); #1 chk("fetch_after_release", state_out[0], StFetch);
    @(posedge clock); #1 chk("no_ir_write_mwait", ir_write[0], 1'b0);
    repeat (2) @(posedge clock);
    #1 chk("ir_write_3_after_fetch", ir_write[0], 1'b1);

    repeat (70) @(posedge clock);

    // Async reset landing in the second wait cycle of the MEM_WAIT=2 instance.
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (state_out[0] == StMwait) found = 1;
    end
    chk("mwait_reached", found, 1'b1);
    if (found) begin
      @(negedge clock);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_immediate", {state_out[0], state_out[1], exc_code[0]},
             {StRstSp, StRstSp, 2'd0});
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      @(posedge clock); #1 chk("refetch_after_async", state_out[0], StFetch);
      repeat (2) @(posedge clock);
      #1 chk("full_wait_after_async", {state_out[0], ir_write[0]}, {StMwait, 1'b0});
      @(posedge clock); #1 chk("ir_load_after_async", ir_write[0], 1'b1);
    end

    repeat (40) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
